// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one external memory bus between the instruction
// fetch port and the data port. One transaction at a time, round-robin on
// ties, active-low ACK handshake, saturating timeout abort.
module mem_bus_arbiter #(
  parameter int         TIMEOUT = 255,
  parameter logic [1:0] IF_SIZE = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        bus_err,
  output logic        stall,
  output logic        MREQ,
  output logic        WRITE,
  output logic [1:0]  SIZE,
  output logic [31:0] AD,
  output logic [31:0] DT_out,
  output logic        DT_oe,
  input  logic [31:0] DT_in,
  input  logic        ACK_n
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic        owner_q;   // 0 = inst, 1 = data
  logic        last_q;    // previous grant, drives tie-break
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_inc;
  logic        grant;
  logic        grant_d;   // requester chosen this cycle
  logic        ack_hit;
  logic        to_hit;

  // Next-state and per-cycle event decode
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    grant_d = 1'b0;
    ack_hit = 1'b0;
    to_hit  = 1'b0;
    cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          grant   = 1'b1;
          grant_d = (if_req && d_req) ? ~last_q : d_req;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!ACK_n) begin
          ack_hit = 1'b1;
          state_d = DONE;
        end else if (cnt_inc >= TO_LIM) begin
          to_hit  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, grant bookkeeping and wait-cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q <= grant_d;
        last_q  <= grant_d;
        cnt_q   <= 8'd0;
      end else if (state_q == BUSY && ACK_n) begin
        cnt_q <= cnt_inc;
      end
    end
  end

  // Registered bus pins; AD/SIZE/DT_out keep their value between accesses
  always_ff @(posedge clk) begin
    if (rst) begin
      MREQ   <= 1'b0;
      WRITE  <= 1'b0;
      DT_oe  <= 1'b0;
      SIZE   <= 2'b00;
      AD     <= 32'd0;
      DT_out <= 32'd0;
    end else if (grant) begin
      MREQ  <= 1'b1;
      WRITE <= grant_d & d_write;
      DT_oe <= grant_d & d_write;
      SIZE  <= grant_d ? d_size : IF_SIZE;
      AD    <= grant_d ? d_addr : if_addr;
      if (grant_d) DT_out <= d_wdata;
    end else if (ack_hit || to_hit) begin
      MREQ  <= 1'b0;
      WRITE <= 1'b0;
      DT_oe <= 1'b0;
    end
  end

  // Completion: one-cycle ready to the owner, read data / abort status
  always_ff @(posedge clk) begin
    if (rst) begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      bus_err  <= 1'b0;
      if_rdata <= 32'd0;
      d_rdata  <= 32'd0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      if (ack_hit || to_hit) begin
        bus_err <= to_hit;
        if (owner_q) begin
          d_ready <= 1'b1;
          if (to_hit)      d_rdata <= 32'd0;
          else if (!WRITE) d_rdata <= DT_in;
        end else begin
          if_ready <= 1'b1;
          if_rdata <= to_hit ? 32'd0 : DT_in;
        end
      end
    end
  end

  // Stall while either requester is still waiting for its ready
  always_comb stall = (if_req & ~if_ready) | (d_req & ~d_ready);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vector table, hand-written corner
// sequences, then random traffic against a transaction-level timeline model.
module tb_mem_bus_arbiter;

  localparam int TB_TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_write;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        bus_err;
  logic        stall;
  logic        MREQ;
  logic        WRITE;
  logic [1:0]  SIZE;
  logic [31:0] AD;
  logic [31:0] DT_out;
  logic        DT_oe;
  logic [31:0] DT_in;
  logic        ACK_n;

  mem_bus_arbiter #(.TIMEOUT(TB_TO), .IF_SIZE(2'b10)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
    .bus_err(bus_err), .stall(stall),
    .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE), .AD(AD), .DT_out(DT_out),
    .DT_oe(DT_oe), .DT_in(DT_in), .ACK_n(ACK_n)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req = 0; if_addr = 0; d_req = 0; d_write = 0; d_size = 0;
    d_addr = 0; d_wdata = 0; DT_in = 0; ACK_n = 1;
  endtask

  // leaves the bench at the start of the first cycle after reset
  task automatic do_reset();
    rst = 1;
    clear_inputs();
    step();
    rst = 0;
  endtask

  typedef struct {
    string       name;
    bit          is_d;
    bit          wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] din;
    int          k;        // wait states before ACK (>= TB_TO: never)
    int          exp_cyc;  // cycle of the ready pulse
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [1:0]  exp_size;
  } vec_t;

  vec_t tv[7];

  int          got, other_seen;
  logic [31:0] g_rd;
  logic        g_err, g_mreq, g_stall;

  // random-phase model state
  bit          m_act, m_own, m_last, m_wr, r_own;
  int          m_bstart, m_rdy, m_free;
  logic [31:0] m_addr, m_wdata, e_if_rd, e_d_rd;
  logic [1:0]  m_size;
  logic        e_err, e_if_rdy, e_d_rdy, p_if_rdy, p_d_rdy;

  initial begin
    tv[0] = '{"fetch0",   0, 0, 2'b10, 32'h100,  32'h0,        32'h00000013, 0,  2, 32'h00000013, 0, 2'b10};
    tv[1] = '{"load1w",   1, 0, 2'b01, 32'h3000, 32'h0,        32'hCAFEF00D, 1,  3, 32'hCAFEF00D, 0, 2'b01};
    tv[2] = '{"store3w",  1, 1, 2'b00, 32'h2000, 32'hDEADBEEF, 32'h5555AAAA, 3,  5, 32'hCAFEF00D, 0, 2'b00};
    tv[3] = '{"load_to",  1, 0, 2'b10, 32'h44,   32'h0,        32'h0,        99, 5, 32'h0,        1, 2'b10};
    tv[4] = '{"fetch_af", 0, 0, 2'b10, 32'h104,  32'h0,        32'h00500093, 0,  2, 32'h00500093, 0, 2'b10};
    tv[5] = '{"fetch2w",  0, 0, 2'b10, 32'h108,  32'h0,        32'h12345678, 2,  4, 32'h12345678, 0, 2'b10};
    tv[6] = '{"fetch_to", 0, 0, 2'b10, 32'h10C,  32'h0,        32'h0,        99, 5, 32'h0,        1, 2'b10};

    rst = 1;
    clear_inputs();
    step();

    // ---- reset state
    do_reset();
    @(negedge clk);
    chk("rst_MREQ", MREQ, 0);   chk("rst_WRITE", WRITE, 0); chk("rst_DT_oe", DT_oe, 0);
    chk("rst_SIZE", SIZE, 0);   chk("rst_AD", AD, 0);       chk("rst_DT_out", DT_out, 0);
    chk("rst_if_rdata", if_rdata, 0); chk("rst_d_rdata", d_rdata, 0);
    chk("rst_if_ready", if_ready, 0); chk("rst_d_ready", d_ready, 0);
    chk("rst_bus_err", bus_err, 0);   chk("rst_stall", stall, 0);
    step();

    // ---- spurious ACK while idle: nothing may happen
    for (int c = 0; c < 4; c++) begin
      ACK_n = 0;
      DT_in = $urandom;
      @(negedge clk);
      chk("spur_MREQ", MREQ, 0);
      chk("spur_rdy", {30'd0, if_ready, d_ready}, 0);
      step();
    end
    ACK_n = 1;

    // ---- directed table (first row also proves the idle state survived)
    for (int i = 0; i < 7; i++) begin
      got = -1; other_seen = 0; g_rd = 0; g_err = 0; g_mreq = 0; g_stall = 0;
      for (int c = 0; c < 10; c++) begin
        if (c == 0) begin
          if (tv[i].is_d) begin
            d_req = 1; d_write = tv[i].wr; d_size = tv[i].size;
            d_addr = tv[i].addr; d_wdata = tv[i].wdata;
          end else begin
            if_req = 1; if_addr = tv[i].addr;
          end
        end
        if (got >= 0 && c == got + 1) begin
          if_req = 0; d_req = 0;
        end
        ACK_n = (c == 1 + tv[i].k) ? 1'b0 : 1'b1;
        DT_in = (c == 1 + tv[i].k) ? tv[i].din : $urandom;
        @(negedge clk);
        if (c <= 1) chk({tv[i].name, "_stall"}, stall, 1);
        if (c == 1) begin
          chk({tv[i].name, "_MREQ"}, MREQ, 1);
          chk({tv[i].name, "_AD"}, AD, tv[i].addr);
          chk({tv[i].name, "_SIZE"}, SIZE, tv[i].exp_size);
          chk({tv[i].name, "_WRITE"}, WRITE, tv[i].wr);
          chk({tv[i].name, "_DT_oe"}, DT_oe, tv[i].wr);
        end
        if (tv[i].wr && c >= 1 && c <= 1 + tv[i].k)
          chk({tv[i].name, "_DT_out"}, DT_out, tv[i].wdata);
        if ((tv[i].is_d ? d_ready : if_ready) && got < 0) begin
          got = c; g_err = bus_err; g_mreq = MREQ; g_stall = stall;
          g_rd = tv[i].is_d ? d_rdata : if_rdata;
        end
        if (tv[i].is_d ? if_ready : d_ready) other_seen = 1;
        step();
      end
      chk({tv[i].name, "_ready_cyc"}, got, tv[i].exp_cyc);
      chk({tv[i].name, "_rdata"}, g_rd, tv[i].exp_rd);
      chk({tv[i].name, "_err"}, g_err, tv[i].exp_err);
      chk({tv[i].name, "_MREQ_done"}, g_mreq, 0);
      chk({tv[i].name, "_stall_done"}, g_stall, 0);
      chk({tv[i].name, "_other_rdy"}, other_seen, 0);
    end

    // ---- simultaneous requests after reset: data, inst, data, inst
    do_reset();
    if_req = 1; if_addr = 32'h400; d_req = 1; d_write = 0; d_size = 2'b10;
    d_addr = 32'h8000; ACK_n = 0;
    for (int c = 0; c < 13; c++) begin
      DT_in = 32'h1000 + c;
      @(negedge clk);
      chk("tie_d_ready", d_ready, (c == 2 || c == 8) ? 1 : 0);
      chk("tie_if_ready", if_ready, (c == 5 || c == 11) ? 1 : 0);
      if (c == 1 || c == 7)  chk("tie_AD_data", AD, 32'h8000);
      if (c == 4 || c == 10) chk("tie_AD_inst", AD, 32'h400);
      if (c == 5) chk("tie_if_rdata", if_rdata, 32'h1000 + 4);
      step();
    end

    // ---- reset in the middle of a fetch, ACK arriving in the reset cycle
    do_reset();
    if_req = 1; if_addr = 32'h200; ACK_n = 1; DT_in = 32'hABCD0001;
    step();
    step();
    rst = 1; ACK_n = 0;
    step();
    rst = 0; if_req = 0; ACK_n = 1;
    @(negedge clk);
    chk("mid_MREQ", MREQ, 0); chk("mid_WRITE", WRITE, 0); chk("mid_DT_oe", DT_oe, 0);
    chk("mid_AD", AD, 0);     chk("mid_SIZE", SIZE, 0);   chk("mid_if_ready", if_ready, 0);
    chk("mid_if_rdata", if_rdata, 0); chk("mid_bus_err", bus_err, 0); chk("mid_stall", stall, 0);
    step();
    @(negedge clk);
    chk("mid_if_ready2", if_ready, 0); chk("mid_MREQ2", MREQ, 0);
    step();
    if_req = 1; if_addr = 32'h204; ACK_n = 0; DT_in = 32'h00000073;
    step();
    @(negedge clk);
    chk("mid_new_MREQ", MREQ, 1); chk("mid_new_AD", AD, 32'h204);
    step();
    @(negedge clk);
    chk("mid_new_ready", if_ready, 1); chk("mid_new_rdata", if_rdata, 32'h73);
    step();
    if_req = 0;

    // ---- random traffic vs. timeline model
    do_reset();
    m_act = 0; m_last = 0; m_own = 0; r_own = 0; m_wr = 0; m_rdy = -1; m_free = 0; m_bstart = 0;
    m_addr = 0; m_wdata = 0; m_size = 0; e_if_rd = 0; e_d_rd = 0; e_err = 0;
    p_if_rdy = 0; p_d_rdy = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!if_req || p_if_rdy) begin
        if_req = ($urandom_range(2) == 0);
        if_addr = {$urandom, 2'b00} & 32'hFFFF_FFFC;
      end
      if (!d_req || p_d_rdy) begin
        d_req = ($urandom_range(2) == 0);
        d_addr = $urandom; d_wdata = $urandom;
        d_write = $urandom_range(1); d_size = 2'($urandom_range(3));
      end
      ACK_n = ($urandom_range(4) < 2) ? 1'b0 : 1'b1;
      DT_in = $urandom;
      @(negedge clk);
      e_if_rdy = (m_rdy == c) && !r_own;
      e_d_rdy  = (m_rdy == c) && r_own;
      chk("rnd_if_ready", if_ready, e_if_rdy);
      chk("rnd_d_ready", d_ready, e_d_rdy);
      chk("rnd_MREQ", MREQ, m_act);
      chk("rnd_stall", stall, (if_req & ~e_if_rdy) | (d_req & ~e_d_rdy));
      chk("rnd_if_rdata", if_rdata, e_if_rd);
      chk("rnd_d_rdata", d_rdata, e_d_rd);
      if (m_act) begin
        chk("rnd_AD", AD, m_addr);
        chk("rnd_SIZE", SIZE, m_size);
        chk("rnd_WRITE", WRITE, m_wr);
        chk("rnd_DT_oe", DT_oe, m_wr);
        if (m_wr) chk("rnd_DT_out", DT_out, m_wdata);
      end
      if (m_rdy == c) chk("rnd_bus_err", bus_err, e_err);
      // end-of-cycle events
      if (m_act) begin
        if (!ACK_n || (c - m_bstart + 1 >= TB_TO)) begin
          e_err = ACK_n;
          if (ACK_n) begin
            if (m_own) e_d_rd = 0; else e_if_rd = 0;
          end else if (!m_wr) begin
            if (m_own) e_d_rd = DT_in; else e_if_rd = DT_in;
          end
          m_act = 0; m_rdy = c + 1; r_own = m_own; m_free = c + 2;
        end
      end else if (c >= m_free && (if_req || d_req)) begin
        m_own   = (if_req && d_req) ? ~m_last : d_req;
        m_last  = m_own;
        m_addr  = m_own ? d_addr : if_addr;
        m_size  = m_own ? d_size : 2'b10;
        m_wr    = m_own & d_write;
        m_wdata = d_wdata;
        m_act   = 1;
        m_bstart = c + 1;
      end
      p_if_rdy = e_if_rdy;
      p_d_rdy  = e_d_rdy;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
